// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with synchroniser, debounce and
// single-key lock. Emits one key code pulse per accepted physical press.
//
// state       | meaning
// ------------+----------------------------------------------------------
// ST_SCAN     | drive one column per dwell period, look for any low row
// ST_DEBOUNCE | candidate (row,col) found, require a stable low row
// ST_HELD     | key accepted and reported, wait for its row to go high
// ST_RELEASE  | row went high, require a stable high row before rescanning
module keypad_scanner #(
  parameter int SCAN_CYCLES     = 2400,
  parameter int DEBOUNCE_CYCLES = 480000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);

  localparam int SW = $clog2(SCAN_CYCLES + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_HELD, ST_RELEASE} state_t;

  state_t        state, state_nxt;
  logic [3:0]    sync1, srow;
  logic [1:0]    col, col_nxt;
  logic [1:0]    row, row_nxt;
  logic [SW-1:0] dwell, dwell_nxt;
  logic [DW-1:0] cnt, cnt_nxt;
  logic [3:0]    key_nxt;
  logic          valid_nxt, held_nxt;
  logic          row_high;

  // Lowest-numbered row that is pulled low wins when several are down.
  function automatic logic [1:0] first_low(input logic [3:0] v);
    if (!v[0])      return 2'd0;
    else if (!v[1]) return 2'd1;
    else if (!v[2]) return 2'd2;
    else            return 2'd3;
  endfunction

  // Keypad legend lookup indexed by {row, col}.
  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: return 4'h1;
      4'h1: return 4'h2;
      4'h2: return 4'h3;
      4'h3: return 4'hA;
      4'h4: return 4'h4;
      4'h5: return 4'h5;
      4'h6: return 4'h6;
      4'h7: return 4'hB;
      4'h8: return 4'h7;
      4'h9: return 4'h8;
      4'hA: return 4'h9;
      4'hB: return 4'hC;
      4'hC: return 4'hE;
      4'hD: return 4'h0;
      4'hE: return 4'hF;
      default: return 4'hD;
    endcase
  endfunction

  assign row_high = srow[row];

  // Two-flop synchroniser for the asynchronous row lines; idles released.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 4'hF;
      srow  <= 4'hF;
    end else begin
      sync1 <= rows;
      srow  <= sync1;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_SCAN;
      col       <= 2'd0;
      row       <= 2'd0;
      dwell     <= '0;
      cnt       <= '0;
      cols      <= 4'b1110;
      key       <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_nxt;
      col       <= col_nxt;
      row       <= row_nxt;
      dwell     <= dwell_nxt;
      cnt       <= cnt_nxt;
      cols      <= ~(4'b0001 << col_nxt);
      key       <= key_nxt;
      key_valid <= valid_nxt;
      key_held  <= held_nxt;
    end
  end

  // Next-state logic; counters clear on every state change and never wrap.
  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    row_nxt   = row;
    dwell_nxt = dwell;
    cnt_nxt   = cnt;
    key_nxt   = key;
    valid_nxt = 1'b0;
    held_nxt  = key_held;
    case (state)
      ST_SCAN: begin
        if (dwell == SCAN_LAST) begin
          dwell_nxt = '0;
          if (srow == 4'hF) begin
            col_nxt = col + 2'd1;
          end else begin
            row_nxt   = first_low(srow);
            cnt_nxt   = '0;
            state_nxt = ST_DEBOUNCE;
          end
        end else begin
          dwell_nxt = dwell + SW'(1);
        end
      end
      ST_DEBOUNCE: begin
        if (row_high) begin
          col_nxt   = col + 2'd1;
          cnt_nxt   = '0;
          dwell_nxt = '0;
          state_nxt = ST_SCAN;
        end else if (cnt == DB_LAST) begin
          key_nxt   = key_code(row, col);
          valid_nxt = 1'b1;
          held_nxt  = 1'b1;
          cnt_nxt   = '0;
          state_nxt = ST_HELD;
        end else begin
          cnt_nxt = cnt + DW'(1);
        end
      end
      ST_HELD: begin
        if (row_high) begin
          cnt_nxt   = '0;
          state_nxt = ST_RELEASE;
        end
      end
      default: begin
        if (!row_high) begin
          cnt_nxt   = '0;
          state_nxt = ST_HELD;
        end else if (cnt == DB_LAST) begin
          held_nxt  = 1'b0;
          col_nxt   = col + 2'd1;
          cnt_nxt   = '0;
          dwell_nxt = '0;
          state_nxt = ST_SCAN;
        end else begin
          cnt_nxt = cnt + DW'(1);
        end
      end
    endcase
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad matrix model plus scoreboard for keypad_scanner.
module tb_keypad_scanner;
  localparam int SCAN = 4;
  localparam int DB   = 8;
  localparam logic [15:0] ROWMAP [4] = '{16'h123A, 16'h456B, 16'h789C, 16'hE0FD};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] rows, cols, key;
  logic       key_valid, key_held;
  logic [3:0] pmat [4] = '{default: 4'h0};

  int vectors = 0;
  int miscompares = 0;
  int pulse_cnt = 0;
  logic [3:0] expq [$];
  logic       prev_valid = 1'b0;
  logic       prev_held = 1'b0;
  logic [3:0] prev_cols = 4'hF;

  keypad_scanner #(.SCAN_CYCLES(SCAN), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .reset(reset), .rows(rows), .cols(cols),
    .key(key), .key_valid(key_valid), .key_held(key_held));

  always #5 clk = ~clk;

  // Physical keypad: a pressed key shorts its row to its column when driven low.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      if ((pmat[r] & ~cols) != 4'h0) rows[r] = 1'b0;
  end

  function automatic logic [3:0] key_of(input int r, input int c);
    logic [15:0] line;
    line = ROWMAP[r];
    return line[(3 - c) * 4 +: 4];
  endfunction

  function automatic logic [3:0] col_drive(input int c);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << (c % 4));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, wanted %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while (expq.size() != 0 && n < budget) begin
      cyc(1);
      n++;
    end
    if (expq.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: %0d expected pulses missing after %0d cycles", name, expq.size(), budget);
      expq.delete();
    end
  endtask

  task automatic wait_release(input string name, input int c);
    int n = 0;
    logic [3:0] ec;
    while (key_held && n < 30) begin
      cyc(1);
      n++;
    end
    check({name, "_latency_ok"}, (n >= DB && n <= DB + 4) ? 1 : 0, 1);
    ec = col_drive(c + 1);
    check({name, "_next_col"}, cols, ec);
  endtask

  // Monitor: pops the scoreboard on each pulse and watches output invariants.
  always @(negedge clk) begin
    logic [3:0] e;
    if (key_valid) begin
      pulse_cnt++;
      if (expq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_pulse: key=%0h, nothing expected at %0t", key, $time);
      end else begin
        e = expq.pop_front();
        check("pulse_key", key, e);
        check("pulse_held", key_held, 1);
      end
      check("pulse_width", prev_valid, 0);
    end
    check("cols_onehot_low", $countones(~cols), 1);
    if (prev_held && key_held) check("cols_stable_held", cols, prev_cols);
    prev_valid = key_valid;
    prev_held  = key_held;
    prev_cols  = cols;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, r, c, g;
    logic [3:0] ec;
    // 1. reset state and idle column stepping
    #1 reset = 1'b0;
    pmat[0][0] = 1'b1;
    cyc(3);
    check("rst_cols", cols, 4'b1110);
    check("rst_key", key, 4'h0);
    check("rst_valid", key_valid, 0);
    check("rst_held", key_held, 0);
    pmat[0][0] = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(i == 0 ? 2 : 4);
      ec = col_drive(i);
      check("idle_scan_cols", cols, ec);
    end

    // 2. clean press of '1'
    pmat[0][0] = 1'b1;
    expq.push_back(key_of(0, 0));
    wait_drain(40, "clean_press_timeout");
    cyc(10);
    pmat[0][0] = 1'b0;
    wait_release("clean_release", 0);
    cyc(6);

    // 3. bouncing press on r3/c1, then stable
    p0 = pulse_cnt;
    for (int i = 0; i < 10; i++) begin
      pmat[3][1] = (i % 2 == 0);
      cyc(3);
    end
    check("bounce_no_pulse", pulse_cnt - p0, 0);
    pmat[3][1] = 1'b1;
    expq.push_back(key_of(3, 1));
    wait_drain(40, "bounce_press_timeout");
    cyc(8);

    // 4. release bounce while held
    p0 = pulse_cnt;
    pmat[3][1] = 1'b0;
    cyc(5);
    pmat[3][1] = 1'b1;
    cyc(15);
    check("relbounce_held", key_held, 1);
    check("relbounce_no_pulse", pulse_cnt - p0, 0);
    pmat[3][1] = 1'b0;
    wait_release("relbounce_release", 1);
    cyc(6);

    // 5. second key held across release of the first
    pmat[2][2] = 1'b1;
    expq.push_back(key_of(2, 2));
    wait_drain(40, "nine_timeout");
    cyc(5);
    p0 = pulse_cnt;
    pmat[1][2] = 1'b1;
    cyc(40);
    check("second_key_ignored", pulse_cnt - p0, 0);
    pmat[2][2] = 1'b0;
    expq.push_back(key_of(1, 2));
    wait_drain(70, "six_timeout");
    cyc(5);
    pmat[1][2] = 1'b0;
    wait_release("six_release", 2);
    cyc(6);

    // 6. reset while debouncing
    reset = 1'b0;
    pmat[0][0] = 1'b1;
    cyc(2);
    reset = 1'b1;
    cyc(8);
    p0 = pulse_cnt;
    reset = 1'b0;
    #1;
    check("midrst_cols", cols, 4'b1110);
    check("midrst_key", key, 4'h0);
    check("midrst_valid", key_valid, 0);
    check("midrst_held", key_held, 0);
    pmat[0][0] = 1'b0;
    cyc(3);
    reset = 1'b1;
    cyc(40);
    check("midrst_no_pulse", pulse_cnt - p0, 0);
    pmat[0][0] = 1'b1;
    expq.push_back(key_of(0, 0));
    wait_drain(40, "midrst_press_timeout");
    cyc(4);
    pmat[0][0] = 1'b0;
    wait_release("midrst_release", 0);
    cyc(6);

    // random sessions: optional bounce, press, optional release glitch, release
    for (int s = 0; s < 16; s++) begin
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin
        p0 = pulse_cnt;
        for (int i = 0; i < int'($urandom_range(4, 10)); i++) begin
          pmat[r][c] = (i % 2 == 0);
          cyc($urandom_range(1, 3));
        end
        pmat[r][c] = 1'b0;
        cyc(2);
        check("rnd_bounce_no_pulse", pulse_cnt - p0, 0);
      end
      pmat[r][c] = 1'b1;
      expq.push_back(key_of(r, c));
      wait_drain(40, "rnd_press_timeout");
      cyc($urandom_range(0, 10));
      if ($urandom_range(0, 1) == 1) begin
        g = $urandom_range(1, 4);
        pmat[r][c] = 1'b0;
        cyc(g);
        pmat[r][c] = 1'b1;
        cyc(10);
        check("rnd_glitch_held", key_held, 1);
      end
      pmat[r][c] = 1'b0;
      wait_release("rnd_release", c);
      cyc($urandom_range(4, 12));
    end

    cyc(20);
    check("queue_empty", expq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
